// File: rtl/onchip_mem_arb_pkg.sv
// rtl/onchip_mem_arb_pkg.sv - shared types and widths for the on-chip RAM arbiter
package onchip_mem_arb_pkg;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } grant_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin / fixed-priority grant with last-grant history
module rr_arb2 #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt_valid,
    output logic gnt_sel
);
    import onchip_mem_arb_pkg::*;

    grant_t last_grant;
    grant_t grant;

    // Reset to M1 so the first conflict after reset goes to M0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_M1;
        end else if (gnt_valid) begin
            last_grant <= grant;
        end
    end

    always_comb begin
        grant     = GNT_M0;
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            if (FIXED_PRIORITY != 0) begin
                grant = GNT_M0;
            end else begin
                grant = (last_grant == GNT_M0) ? GNT_M1 : GNT_M0;
            end
        end else if (req1) begin
            grant = GNT_M1;
        end
    end

    assign gnt_sel = (grant == GNT_M1);
endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-master arbiter for the single-port on-chip RAM
module onchip_mem_arbiter #(
    parameter int  ADDR_W         = 14,
    parameter int  DATA_W         = 32,
    parameter int  FIXED_PRIORITY = 0,
    localparam int BE_W           = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);
    import onchip_mem_arb_pkg::*;

    logic     req0, req1;
    logic     arb_valid, arb_m1;
    logic     gnt_valid, gnt_m0, gnt_m1;
    logic     rd_pend;
    grant_t   rd_owner;
    mem_req_t m0_req, m1_req, sel_req;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    rr_arb2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .gnt_valid (arb_valid),
        .gnt_sel   (arb_m1)
    );

    // Reset blocks the RAM port immediately, not just at the next edge.
    assign gnt_valid = arb_valid & ~reset;
    assign gnt_m0    = gnt_valid & ~arb_m1;
    assign gnt_m1    = gnt_valid & arb_m1;

    always_comb begin
        m0_req.addr  = m0_address;
        m0_req.be    = m0_write ? m0_byteenable : '1;
        m0_req.wr    = m0_write;
        m0_req.wdata = m0_writedata;
        m1_req.addr  = m1_address;
        m1_req.be    = m1_write ? m1_byteenable : '1;
        m1_req.wr    = m1_write;
        m1_req.wdata = m1_writedata;
        sel_req      = gnt_m1 ? m1_req : m0_req;
    end

    assign mem_address    = sel_req.addr;
    assign mem_byteenable = sel_req.be;
    assign mem_writedata  = sel_req.wdata;
    assign mem_chipselect = gnt_valid;
    assign mem_write      = gnt_valid & sel_req.wr;
    assign mem_clken      = 1'b1;

    assign m0_waitrequest = reset | (req0 & ~gnt_m0);
    assign m1_waitrequest = reset | (req1 & ~gnt_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= GNT_M0;
        end else begin
            rd_pend <= gnt_valid & ~sel_req.wr;
            if (gnt_valid && !sel_req.wr) begin
                rd_owner <= grant_t'(arb_m1);
            end
        end
    end

    // RAM q is shared; only the valid strobe tells the masters apart.
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend & (rd_owner == GNT_M0);
    assign m1_readdatavalid = rd_pend & (rd_owner == GNT_M1);

    a_m0_rw_excl: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
    a_m1_rw_excl: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - self-checking bench for onchip_mem_arbiter
module tb_onchip_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [13:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        mem_chipselect, mem_write, mem_clken;

    logic [13:0] f_m0_address, f_m1_address, f_mem_address;
    logic [3:0]  f_m0_byteenable, f_m1_byteenable, f_mem_byteenable;
    logic        f_m0_read, f_m0_write, f_m1_read, f_m1_write;
    logic [31:0] f_m0_writedata, f_m1_writedata, f_mem_writedata;
    logic [31:0] f_mem_readdata = 32'h0;
    logic        f_m0_waitrequest, f_m1_waitrequest, f_m0_readdatavalid, f_m1_readdatavalid;
    logic [31:0] f_m0_readdata, f_m1_readdata;
    logic        f_mem_chipselect, f_mem_write, f_mem_clken;

    int total = 0;
    int bad   = 0;

    onchip_mem_arbiter #(.FIXED_PRIORITY(0)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    onchip_mem_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_address(f_m0_address), .m0_byteenable(f_m0_byteenable), .m0_read(f_m0_read),
        .m0_write(f_m0_write), .m0_writedata(f_m0_writedata), .m0_waitrequest(f_m0_waitrequest),
        .m0_readdata(f_m0_readdata), .m0_readdatavalid(f_m0_readdatavalid),
        .m1_address(f_m1_address), .m1_byteenable(f_m1_byteenable), .m1_read(f_m1_read),
        .m1_write(f_m1_write), .m1_writedata(f_m1_writedata), .m1_waitrequest(f_m1_waitrequest),
        .m1_readdata(f_m1_readdata), .m1_readdatavalid(f_m1_readdatavalid),
        .mem_address(f_mem_address), .mem_byteenable(f_mem_byteenable),
        .mem_chipselect(f_mem_chipselect), .mem_write(f_mem_write),
        .mem_writedata(f_mem_writedata), .mem_clken(f_mem_clken), .mem_readdata(f_mem_readdata)
    );

    // Stand-in RAM: registered address, q valid the cycle after a read.
    logic [31:0] ram [0:16383];
    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        mem_readdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
        m0_writedata = '0; m1_writedata = '0;
        f_m0_read = 0; f_m0_write = 0; f_m1_read = 0; f_m1_write = 0;
        f_m0_address = '0; f_m1_address = '0; f_m0_byteenable = '0; f_m1_byteenable = '0;
        f_m0_writedata = '0; f_m1_writedata = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        m0_read = 1;
        #1;
        total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait0: got %b want 1", m0_waitrequest); end
        total++; if (mem_chipselect !== 1'b0) begin bad++; $display("FAIL rst_cs: got %b want 0", mem_chipselect); end
        total++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
            bad++; $display("FAIL rst_valid: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
        reset = 0;
        @(negedge clk);
        total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL post_rst_wait0: got %b want 0", m0_waitrequest); end
        tick();
        #2;
        total++; if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL pre_async_valid: got %b want 1", m0_readdatavalid); end
        reset = 1;
        #1;
        total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", m0_readdatavalid); end
        total++; if (mem_chipselect !== 1'b0) begin bad++; $display("FAIL async_cs: got %b want 0", mem_chipselect); end
        total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL async_wait0: got %b want 1", m0_waitrequest); end
        clear_inputs();
        tick();
        reset = 0;
    endtask

    task automatic test_write_read();
        m0_write = 1; m0_address = 14'h0010; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL wr_wait: got %b want 0", m0_waitrequest); end
        total++; if (mem_write !== 1'b1 || mem_chipselect !== 1'b1) begin
            bad++; $display("FAIL wr_mem: got w=%b cs=%b want 1 1", mem_write, mem_chipselect); end
        tick();
        m0_write = 0; m0_read = 1;
        @(negedge clk);
        total++; if (mem_write !== 1'b0 || mem_byteenable !== 4'hF) begin
            bad++; $display("FAIL rd_mem: got w=%b be=%h want 0 f", mem_write, mem_byteenable); end
        tick();
        m0_read = 0;
        @(negedge clk);
        total++; if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL rd_valid0: got %b want 1", m0_readdatavalid); end
        total++; if (m0_readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data0: got %h want deadbeef", m0_readdata); end
        total++; if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_valid1: got %b want 0", m1_readdatavalid); end
        tick();
        @(negedge clk);
        total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_pulse: got %b want 0", m0_readdatavalid); end
        tick();
    endtask

    task automatic test_byte_write();
        m1_write = 1; m1_address = 14'h0020; m1_byteenable = 4'hF; m1_writedata = 32'h11223344;
        @(negedge clk);
        total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL bw_wait: got %b want 0", m1_waitrequest); end
        tick();
        m1_byteenable = 4'b0100; m1_writedata = 32'h00AB0000;
        @(negedge clk);
        total++; if (mem_byteenable !== 4'b0100 || mem_writedata !== 32'h00AB0000) begin
            bad++; $display("FAIL bw_lanes: got be=%h d=%h want 4 00ab0000", mem_byteenable, mem_writedata); end
        tick();
        m1_write = 0; m1_read = 1;
        tick();
        m1_read = 0;
        @(negedge clk);
        total++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h11AB3344) begin
            bad++; $display("FAIL bw_read: got v=%b d=%h want 1 11ab3344", m1_readdatavalid, m1_readdata); end
        total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL bw_other: got %b want 0", m0_readdatavalid); end
        tick();
    endtask

    // Previous grant went to m1, so alternation starts with m0.
    task automatic test_rr_alternate();
        logic exp_m1;
        logic [31:0] exp_d;
        m0_read = 1; m0_address = 14'h0010;
        m1_read = 1; m1_address = 14'h0020;
        for (int i = 0; i < 6; i++) begin
            exp_m1 = (i % 2) == 1;
            @(negedge clk);
            total++; if (m0_waitrequest !== exp_m1 || m1_waitrequest !== !exp_m1) begin
                bad++; $display("FAIL rr_wait[%0d]: got %b%b want %b%b", i, m0_waitrequest, m1_waitrequest, exp_m1, !exp_m1); end
            if (i > 0) begin
                exp_d = exp_m1 ? 32'hDEADBEEF : 32'h11AB3344;
                total++; if (m0_readdatavalid !== exp_m1 || m1_readdatavalid !== !exp_m1 || m0_readdata !== exp_d) begin
                    bad++; $display("FAIL rr_ret[%0d]: got v=%b%b d=%h want v=%b%b d=%h", i,
                        m0_readdatavalid, m1_readdatavalid, m0_readdata, exp_m1, !exp_m1, exp_d); end
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        total++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h11AB3344) begin
            bad++; $display("FAIL rr_last: got v=%b d=%h want 1 11ab3344", m1_readdatavalid, m1_readdata); end
        tick();
    endtask

    task automatic test_fixed_priority();
        f_m0_write = 1; f_m0_address = 14'h0001; f_m0_byteenable = 4'hF; f_m0_writedata = 32'hA5A5A5A5;
        f_m1_write = 1; f_m1_address = 14'h0002; f_m1_byteenable = 4'hF; f_m1_writedata = 32'h5A5A5A5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (f_m0_waitrequest !== 1'b0 || f_m1_waitrequest !== 1'b1 || f_mem_address !== 14'h0001) begin
                bad++; $display("FAIL fp_hold[%0d]: got w=%b%b a=%h want 01 0001", i,
                    f_m0_waitrequest, f_m1_waitrequest, f_mem_address); end
            tick();
        end
        f_m0_write = 0;
        @(negedge clk);
        total++; if (f_m1_waitrequest !== 1'b0 || f_mem_address !== 14'h0002 || f_mem_write !== 1'b1) begin
            bad++; $display("FAIL fp_release: got w=%b a=%h mw=%b want 0 0002 1", f_m1_waitrequest, f_mem_address, f_mem_write); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        m1_read = 1; m1_address = 14'h0020;
        @(negedge clk);
        total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL rmr_accept: got %b want 0", m1_waitrequest); end
        tick();
        m1_read = 0;
        reset = 1;
        #1;
        total++; if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rmr_lost: got %b want 0", m1_readdatavalid); end
        tick();
        reset = 0;
        m0_read = 1; m0_address = 14'h0010;
        m1_read = 1; m1_address = 14'h0020;
        @(negedge clk);
        total++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            bad++; $display("FAIL rmr_first: got %b%b want 01", m0_waitrequest, m1_waitrequest); end
        total++; if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rmr_stale: got %b want 0", m1_readdatavalid); end
        tick();
        m0_read = 0;
        @(negedge clk);
        total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF || m1_waitrequest !== 1'b0) begin
            bad++; $display("FAIL rmr_second: got v=%b d=%h w1=%b want 1 deadbeef 0", m0_readdatavalid, m0_readdata, m1_waitrequest); end
        tick();
        clear_inputs();
        tick();
    endtask

    // Random traffic on words 0x100-0x107, checked against a rule-level model.
    task automatic test_random();
        bit          act [2];
        bit          isw [2];
        logic [13:0] ad  [2];
        logic [3:0]  be  [2];
        logic [31:0] wd  [2];
        logic [31:0] model [0:7];
        int          last, w, powner;
        bit          pv;
        logic [31:0] pdata;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        for (int m = 0; m < 2; m++) act[m] = 0;
        reset = 1;
        clear_inputs();
        tick();
        reset = 0;
        last = 1; pv = 0; powner = 0; pdata = '0;
        for (int c = 0; c < 300; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 9) < 6) begin
                    act[m] = 1;
                    isw[m] = 1'($urandom_range(0, 1));
                    ad[m]  = 14'h0100 + 14'($urandom_range(0, 7));
                    be[m]  = 4'($urandom_range(1, 15));
                    wd[m]  = $urandom;
                end
            end
            m0_read = act[0] & !isw[0]; m0_write = act[0] & isw[0];
            m0_address = ad[0]; m0_byteenable = be[0]; m0_writedata = wd[0];
            m1_read = act[1] & !isw[1]; m1_write = act[1] & isw[1];
            m1_address = ad[1]; m1_byteenable = be[1]; m1_writedata = wd[1];
            if (act[0] && act[1]) w = 1 - last;
            else if (act[0])      w = 0;
            else if (act[1])      w = 1;
            else                  w = -1;
            @(negedge clk);
            total++; if (m0_waitrequest !== (act[0] && w != 0) || m1_waitrequest !== (act[1] && w != 1)) begin
                bad++; $display("FAIL rnd_wait[%0d]: got %b%b want %b%b", c, m0_waitrequest, m1_waitrequest,
                    act[0] && w != 0, act[1] && w != 1); end
            total++; if (m0_readdatavalid !== (pv && powner == 0) || m1_readdatavalid !== (pv && powner == 1)) begin
                bad++; $display("FAIL rnd_valid[%0d]: got %b%b want %b%b", c, m0_readdatavalid, m1_readdatavalid,
                    pv && powner == 0, pv && powner == 1); end
            if (pv) begin
                total++; if (m0_readdata !== pdata || m1_readdata !== pdata) begin
                    bad++; $display("FAIL rnd_data[%0d]: got %h/%h want %h", c, m0_readdata, m1_readdata, pdata); end
            end
            pv = 0;
            if (w >= 0) begin
                if (isw[w]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[w][b]) model[ad[w][2:0]][8*b +: 8] = wd[w][8*b +: 8];
                end else begin
                    pv = 1; powner = w; pdata = model[ad[w][2:0]];
                end
                act[w] = 0;
                last = w;
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        total++; if (m0_readdatavalid !== (pv && powner == 0) || m1_readdatavalid !== (pv && powner == 1)) begin
            bad++; $display("FAIL rnd_tail: got %b%b want %b%b", m0_readdatavalid, m1_readdatavalid,
                pv && powner == 0, pv && powner == 1); end
        tick();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_write_read();
        test_byte_write();
        test_rr_alternate();
        test_fixed_priority();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
